npu_core: RTL and testbench

Instruction-driven compute core of the FPGA NPU. It sits behind the PCIe host-interface stream and in front of the local data memory. It accepts one 32-bit instruction at a time from the host stream and executes an arithmetic, MAC or memory op. It returns one 32-bit result word per instruction on the host output stream. Execution is not pipelined: at most one instruction is in flight.

---
 rtl/npu_pkg.sv | 28 ++
 rtl/npu_alu.sv | 37 +++
 rtl/npu_core.sv | 147 ++++++++++++++
 tb/tb_npu_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared opcode, state and instruction-field definitions for the NPU core.
package npu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_MAC   = 8'h04;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_STORE = 8'h11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM_WAIT  = 3'd3,
    WRITEBACK = 3'd4
  } state_e;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int A_MSB  = 23;
  localparam int A_LSB  = 16;
  localparam int B_MSB  = 15;
  localparam int B_LSB  = 8;
  localparam int D_MSB  = 7;
  localparam int D_LSB  = 0;

endpackage

// File: rtl/npu_alu.sv
// Combinational ADD/SUB/MUL/MAC datapath; any op that is not MAC yields a
// cleared next accumulator.
module npu_alu
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [7:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] acc_next_o
);

  logic [DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0] mac_sum;

  assign prod    = a_i * b_i;
  assign mac_sum = acc_i + prod;

  always_comb begin
    result_o   = '0;
    acc_next_o = '0;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_MUL: result_o = prod;
      OP_MAC: begin
        result_o   = mac_sum;
        acc_next_o = mac_sum;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/npu_core.sv
// Non-pipelined instruction core: one host instruction in flight, executed as
// an ALU op or a single memory transaction, one result word returned per op.
module npu_core
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PE_COUNT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] host_data_in,
  input  logic                  host_data_in_valid,
  output logic                  host_data_in_ready,
  output logic [DATA_WIDTH-1:0] host_data_out,
  output logic                  host_data_out_valid,
  input  logic                  host_data_out_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic                  mem_valid,
  output logic [3:0]            status
);

  if (PE_COUNT < 1) begin : g_pe_chk
    $error("npu_core: PE_COUNT must be >= 1");
  end

  state_e                state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            a_q, a_d, b_q, b_d, d_q, d_d;
  logic                  is_ld_q, is_ld_d, is_st_q, is_st_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] alu_result, alu_acc_next;
  logic                  exec_ld, exec_st;

  npu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i       (op_q),
    .a_i        (DATA_WIDTH'(a_q)),
    .b_i        (DATA_WIDTH'(b_q)),
    .acc_i      (acc_q),
    .result_o   (alu_result),
    .acc_next_o (alu_acc_next)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    is_ld_d  = is_ld_q;
    is_st_d  = is_st_q;
    result_d = result_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (host_data_in_valid && rdy_q) begin
          instr_d = host_data_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        op_d    = instr_q[OP_MSB:OP_LSB];
        a_d     = instr_q[A_MSB:A_LSB];
        b_d     = instr_q[B_MSB:B_LSB];
        d_d     = instr_q[D_MSB:D_LSB];
        is_ld_d = (instr_q[OP_MSB:OP_LSB] == OP_LOAD);
        is_st_d = (instr_q[OP_MSB:OP_LSB] == OP_STORE);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (is_ld_q || is_st_q) begin
          state_d = MEM_WAIT;
        end else begin
          // invalid opcodes fall through the ALU as result 0, acc cleared
          result_d = alu_result;
          acc_d    = alu_acc_next;
          state_d  = WRITEBACK;
        end
      end
      MEM_WAIT: begin
        if (mem_valid) begin
          result_d = is_ld_q ? mem_rdata : DATA_WIDTH'(a_q);
          acc_d    = '0;
          state_d  = WRITEBACK;
        end
      end
      WRITEBACK: begin
        if (host_data_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is registered so it reads 0 while reset is held
  assign rdy_d = (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      instr_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      is_ld_q  <= 1'b0;
      is_st_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      instr_q  <= instr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      is_ld_q  <= is_ld_d;
      is_st_q  <= is_st_d;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign exec_ld = (state_q == EXECUTE) && is_ld_q;
  assign exec_st = (state_q == EXECUTE) && is_st_q;

  assign mem_re    = exec_ld;
  assign mem_we    = exec_st;
  assign mem_addr  = exec_ld ? ADDR_WIDTH'(a_q) :
                     exec_st ? ADDR_WIDTH'(d_q) : '0;
  assign mem_wdata = exec_st ? DATA_WIDTH'(a_q) : '0;

  assign host_data_in_ready  = rdy_q;
  assign host_data_out       = result_q;
  assign host_data_out_valid = (state_q == WRITEBACK);
  assign status              = {1'b0, state_q};

endmodule

// File: tb/tb_npu_core.sv
// Randomised self-checking bench for npu_core with a behavioural result model
// and a variable-latency memory responder.
module tb_npu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] host_data_in = '0;
  logic        host_data_in_valid = 1'b0;
  logic        host_data_in_ready;
  logic [31:0] host_data_out;
  logic        host_data_out_valid;
  logic        host_data_out_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        mem_re;
  logic        mem_valid;
  logic [3:0]  status;

  npu_core #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PE_COUNT(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .host_data_in        (host_data_in),
    .host_data_in_valid  (host_data_in_valid),
    .host_data_in_ready  (host_data_in_ready),
    .host_data_out       (host_data_out),
    .host_data_out_valid (host_data_out_valid),
    .host_data_out_ready (host_data_out_ready),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_we              (mem_we),
    .mem_re              (mem_re),
    .mem_valid           (mem_valid),
    .status              (status)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int re_cnt = 0, we_cnt = 0, bad_strb = 0, beats = 0, n_issued = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [31:0] mem   [256];
  logic [31:0] mem_m [256];
  logic [31:0] acc_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result and accumulator rules straight from the opcode table.
  function automatic logic [31:0] model(logic [7:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] d);
    logic [31:0] ua, ub, r;
    ua = {24'd0, a};
    ub = {24'd0, b};
    r  = 32'd0;
    case (op)
      8'h01: r = ua + ub;
      8'h02: r = ua - ub;
      8'h03: r = ua * ub;
      8'h04: begin acc_m = acc_m + ua * ub; r = acc_m; end
      8'h10: r = mem_m[a];
      8'h11: begin mem_m[d] = ua; r = ua; end
      default: r = 32'd0;
    endcase
    if (op != 8'h04) acc_m = 32'd0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (mem_re) begin re_cnt++; last_addr = mem_addr; end
    if (mem_we) begin we_cnt++; last_addr = mem_addr; last_wdata = mem_wdata; end
    if ((mem_re || mem_we) && status != 4'd2) bad_strb++;
    if (rst_n && host_data_out_valid && host_data_out_ready) beats++;
  end

  // Memory device: completion 0..3 cycles after the core enters MEM_WAIT.
  initial begin
    int w;
    logic [7:0] addr;
    logic is_rd;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_re || mem_we)) begin
        addr  = mem_addr[7:0];
        is_rd = mem_re;
        if (mem_we) mem[addr] = mem_wdata;
        w = $urandom_range(0, 3);
        @(negedge clk);
        repeat (w) @(negedge clk);
        mem_rdata = is_rd ? mem[addr] : $urandom;
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the handshake edge.
  task automatic run_instr(input logic [7:0] op, a, b, d, input int hold,
                           output logic [31:0] got);
    int n;
    logic stable;
    n = 0;
    while (!host_data_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", {31'd0, host_data_in_ready}, 32'd1);
    host_data_out_ready = (hold == 0);
    host_data_in = {op, a, b, d};
    host_data_in_valid = 1'b1;
    @(posedge clk); #1;
    host_data_in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, host_data_in_ready}, 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!host_data_out_valid && n < 200);
    chk("out_valid_seen", {31'd0, host_data_out_valid}, 32'd1);
    got = host_data_out;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (host_data_out !== got || host_data_out_valid !== 1'b1) stable = 1'b0;
      end
      chk("hold_stable", {31'd0, stable}, 32'd1);
      @(posedge clk); #1;
      host_data_out_ready = 1'b1;
    end
    @(posedge clk); #1;
    host_data_in = '0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] op, a, b, d, input int hold);
    logic [31:0] exp, got;
    int s_re, s_we;
    exp  = model(op, a, b, d);
    s_re = re_cnt;
    s_we = we_cnt;
    run_instr(op, a, b, d, hold, got);
    n_issued++;
    chk(tag, got, exp);
    chk({tag, "_re"}, re_cnt - s_re, (op == 8'h10) ? 32'd1 : 32'd0);
    chk({tag, "_we"}, we_cnt - s_we, (op == 8'h11) ? 32'd1 : 32'd0);
    if (op == 8'h10) chk({tag, "_raddr"}, last_addr, {24'd0, a});
    if (op == 8'h11) begin
      chk({tag, "_waddr"}, last_addr, {24'd0, d});
      chk({tag, "_wdata"}, last_wdata, {24'd0, a});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int r;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = $urandom;
      mem_m[i] = mem[i];
    end
    mem[50]  = 32'hABCDEF01; mem_m[50]  = 32'hABCDEF01;
    mem[255] = 32'hDEADDEAD; mem_m[255] = 32'hDEADDEAD;

    #2;
    chk("rst_in_ready",  {31'd0, host_data_in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, host_data_out_valid}, 32'd0);
    chk("rst_out_data",  host_data_out, 32'd0);
    chk("rst_strobes",   {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'd0);
    chk("rst_status",    {28'd0, status}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_status",   {28'd0, status}, 32'd0);
    chk("idle_in_ready", {31'd0, host_data_in_ready}, 32'd1);

    do_op("add", 8'h01, 8'd100, 8'd200, 8'd0, 0);
    do_op("sub", 8'h02, 8'd244, 8'd200, 8'd0, 0);
    do_op("sub_wrap", 8'h02, 8'd5, 8'd200, 8'd0, 0);
    do_op("mul", 8'h03, 8'd10, 8'd20, 8'd0, 0);
    do_op("mac0", 8'h04, 8'd5, 8'd6, 8'd0, 0);
    do_op("mac1", 8'h04, 8'd10, 8'd10, 8'd0, 0);
    do_op("add_clr", 8'h01, 8'd0, 8'd0, 8'd0, 0);
    do_op("mac2", 8'h04, 8'd2, 8'd3, 8'd0, 0);
    do_op("mac3", 8'h04, 8'd4, 8'd5, 8'd0, 0);
    do_op("mac4", 8'h04, 8'd6, 8'd7, 8'd0, 0);
    do_op("store", 8'h11, 8'd120, 8'd0, 8'd100, 0);
    do_op("load50", 8'h10, 8'd50, 8'd0, 8'd0, 0);
    do_op("load100", 8'h10, 8'd100, 8'd0, 8'd0, 0);
    do_op("bad_op", 8'hFF, 8'd12, 8'd34, 8'd56, 0);
    do_op("load255", 8'h10, 8'd255, 8'd0, 8'd0, 0);
    do_op("mac_max", 8'h04, 8'd255, 8'd255, 8'd0, 0);
    for (int i = 0; i < 5; i++)
      do_op("b2b_add", 8'h01, 8'(10 + i), 8'(20 + i), 8'd0, 0);
    do_op("bp_add", 8'h01, 8'd100, 8'd200, 8'd0, 20);
    chk("bp_idle_rdy", {31'd0, host_data_in_ready}, 32'd1);
    chk("bp_idle_st",  {28'd0, status}, 32'd0);

    // Abandon an in-flight MAC by reset; accumulator must restart from zero.
    do_op("pre_rst_mac", 8'h04, 8'd3, 8'd3, 8'd0, 0);
    host_data_in = {8'h04, 8'd4, 8'd4, 8'd0};
    host_data_in_valid = 1'b1;
    @(posedge clk); #1;
    host_data_in_valid = 1'b0;
    rst_n = 1'b0;
    acc_m = '0;
    @(posedge clk); #1;
    chk("midrst_valid",  {31'd0, host_data_out_valid}, 32'd0);
    chk("midrst_status", {28'd0, status}, 32'd0);
    chk("midrst_ready",  {31'd0, host_data_in_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    do_op("post_rst_mac", 8'h04, 8'd1, 8'd1, 8'd0, 0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3, 7: op = 8'h04;
        4: op = 8'h10;
        5: op = 8'h11;
        default: op = 8'($urandom_range(0, 255));
      endcase
      do_op("rnd", op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    repeat (2) @(posedge clk); #1;
    chk("beat_count", beats, n_issued);
    chk("strobe_outside_exec", bad_strb, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
